// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// then a registered one-cycle write-back toward the register file.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [4:0]      i_rd_addr,
    output logic            o_ready,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_wb_addr,
    output logic            o_wb_we
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [4:0]      r_cnt;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_neg;
    logic            r_div0;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_wb_addr;
    logic            r_done;
    logic            r_wb_we;

    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_borrow;

    // Two's-complement magnitude when the operand is treated as signed and negative.
    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] m;
        if (sgn && v[XLEN-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Apply sign correction and select the architectural result from the final datapath.
    function automatic logic [XLEN-1:0] f_finalize(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            neg,
        input logic            div0
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = {hi, lo};
        if (neg) begin
            prod = -prod;
        end else begin
            prod = {hi, lo};
        end
        case (f3)
            3'b000:                  res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (div0) begin
                    res = {XLEN{1'b1}};
                end else if (neg) begin
                    res = -lo;
                end else begin
                    res = lo;
                end
            end
            3'b110, 3'b111:          res = neg ? -hi : hi;
            default:                 res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                        (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign w_b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
                        (i_funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && i_rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed && i_rs2_val[XLEN-1];
    assign w_a_mag    = f_mag(i_rs1_val, w_a_signed);
    assign w_b_mag    = f_mag(i_rs2_val, w_b_signed);
    // Remainder follows the dividend; quotient and product follow the sign mismatch.
    assign w_neg      = (i_funct3[2:1] == 2'b11) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_rem_shift = {r_hi, r_lo[XLEN-1]};
    assign w_borrow    = w_rem_shift < {1'b0, r_opb};
    assign w_diff      = w_rem_shift[XLEN-1:0] - r_opb;

    assign o_ready   = (r_state != S_RUN);
    assign o_done    = r_done;
    assign o_result  = r_result;
    assign o_wb_addr = r_wb_addr;
    assign o_wb_we   = r_wb_we;

    // State register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_state_nx = (r_cnt == 5'd31) ? S_DONE : S_RUN;
            S_DONE:  w_state_nx = w_accept ? S_RUN : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Operand capture and one shift-add / restoring-divide step per RUN cycle.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_cnt    <= 5'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 5'd0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= {XLEN{1'b0}};
            r_lo     <= {XLEN{1'b0}};
            r_opb    <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_cnt    <= 5'd0;
            r_funct3 <= i_funct3;
            r_rd     <= i_rd_addr;
            r_neg    <= w_neg;
            r_div0   <= (i_rs2_val == {XLEN{1'b0}});
            r_hi     <= {XLEN{1'b0}};
            // Multiply keeps the multiplier in lo; divide shifts the dividend out of lo.
            r_lo     <= i_funct3[2] ? w_a_mag : w_b_mag;
            r_opb    <= i_funct3[2] ? w_b_mag : w_a_mag;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_funct3[2]) begin
                r_hi <= w_borrow ? w_rem_shift[XLEN-1:0] : w_diff;
                r_lo <= {r_lo[XLEN-2:0], ~w_borrow};
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    // Registered write-back, launched from the DONE state.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_result  <= {XLEN{1'b0}};
            r_wb_addr <= 5'd0;
            r_done    <= 1'b0;
            r_wb_we   <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_result  <= f_finalize(r_funct3, r_hi, r_lo, r_neg, r_div0);
            r_wb_addr <= r_rd;
            r_done    <= 1'b1;
            r_wb_we   <= (r_rd != 5'd0);
        end else begin
            r_done    <= 1'b0;
            r_wb_we   <= 1'b0;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting between the register file read ports and its write port. It takes rs1/rs2 operand values (RD1/RD2), computes one of the eight M-extension operations over a fixed 33-cycle sequence, and drives a one-cycle write-back (WD3/A3/WE3) to the register file. Control stalls the pipeline while `ready` is low.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state changes on posedge.
- `areset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only when `ready`=1.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  32  operand A (dividend / multiplicand), from RD1.
- `rs2_val`  in  32  operand B (divisor / multiplier), from RD2.
- `rd_addr`  in  5  destination register.
- `ready`  out  1  unit can accept `start` this cycle.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  32  operation result, to WD3.
- `wb_addr`  out  5  captured `rd_addr`, to A3.
- `wb_we`  out  1  write enable to WE3; = `done` & (`wb_addr`≠0).

## Operation
- States: IDLE, RUN, DONE. `ready`=1 in IDLE and DONE, 0 in RUN.
- IDLE/DONE + `start`=1: capture `funct3`, `rd_addr`, and operands; load 5-bit iteration counter with 0; go RUN. Otherwise DONE → IDLE, IDLE → IDLE.
- `start` while in RUN: ignored, no capture, no error.
- RUN: one iteration per cycle, 32 iterations; after the iteration with counter=31, go DONE.
- Multiply: convert to magnitudes per signedness (MULH both signed, MULHSU rs1 signed / rs2 unsigned, MULHU and MUL unsigned); 64-bit shift-add, one multiplier bit per iteration; negate 64-bit product if exactly one signed operand is negative. MUL → product[31:0], MULH* → product[63:32].
- Divide: restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned), one quotient bit per iteration. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
- Special cases are resolved at the RUN→DONE transition. They do not shorten latency.
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- DONE: `result` and `wb_addr` registered and valid; `done`=1 for exactly this cycle.
- `result`/`wb_addr` hold their last values after DONE until the next DONE.
- `rd_addr`=0: computation runs normally, `done` pulses, `wb_we` stays 0. The register file writes x0 unconditionally, so suppression here is mandatory.

## Timing
- Reset (async, `areset`=0): state IDLE, `ready`=1, `done`=0, `wb_we`=0, `result`=0, `wb_addr`=0, all internal datapath registers 0. Outputs take reset values immediately, without waiting for a clock.
- Reset asserted mid-RUN or in DONE: operation abandoned, no write-back pulse after release.
- Latency: `start` sampled at edge E0 → RUN during cycles E1..E32 → `done`/`wb_we` high between E33 and E34.
- Back-to-back: `start` during the DONE cycle is accepted at E33. The next `done` follows at E66. No bubble is needed.
- Throughput: one op per 33 cycles.
- Operands are sampled only at the accept edge; `rs1_val`/`rs2_val` may change afterwards.
- No combinational path from inputs to `done`, `result`, `wb_addr`, `wb_we`. `ready` is decoded from state only.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → `result`=0xFFFFFFEB, `wb_addr`=5, `wb_we`=1 for exactly one cycle, 33 edges after the start edge. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIV 1234/0 → 0xFFFFFFFF; REMU 1234/0 → 1234. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0. All complete at the normal latency.
- Control: `start` pulsed in RUN → ignored, single `done`. `start` held in DONE → second op accepted, `done` at E33 and E66. rd=0 → `done`=1 with `wb_we`=0.
- Reset: assert `areset`=0 at E10 of a DIV → outputs immediately at reset values. After release, no `done`/`wb_we` is seen, and `ready`=1.
